// File: rtl/rtc_bus_pkg.sv
// Shared types for the RTC multiplexed-bus engine.
// State encoding order matters: phases advance by incrementing.
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    A_SET = 3'd1,
    A_STB = 3'd2,
    A_HLD = 3'd3,
    D_SET = 3'd4,
    D_STB = 3'd5,
    D_HLD = 3'd6,
    GAP   = 3'd7
  } rtc_state_t;

  // {cs_n, ad_n, wr_n, rd_n} with the bus parked
  localparam logic [3:0] BUS_IDLE = 4'b1111;

endpackage

// File: rtl/rtc_phase_timer.sv
// Phase timer: reloads on every state change and flags the
// last clock of each PHASE_CYC-long bus phase.
module rtc_phase_timer #(
  parameter int PHASE_CYC = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic phase_end
);

  localparam int CW = $clog2(PHASE_CYC + 1);
  localparam logic [CW-1:0] TOP = CW'(PHASE_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || load)
      cnt <= TOP;
    else if (cnt != '0)
      cnt <= cnt - CW'(1);
  end

  assign phase_end = (cnt == '0);

endmodule

// File: rtl/rtc_bus_engine.sv
// Multiplexed address/data bus engine for the external RTC.
// Build option RTC_READBACK_EN: verify every write with a read-back.
module rtc_bus_engine
  import rtc_bus_pkg::*;
#(
  parameter int PHASE_CYC = 4,
  parameter int AW = 8,
  parameter int DW = 8,
  localparam int ADW = (AW > DW) ? AW : DW
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic           wr,
  input  logic [AW-1:0]  addr,
  input  logic [DW-1:0]  wdata,
  output logic [DW-1:0]  rdata,
  output logic           done,
  output logic           busy,
  output logic           err,
  output logic           rtc_cs_n,
  output logic           rtc_ad_n,
  output logic           rtc_wr_n,
  output logic           rtc_rd_n,
  output logic [ADW-1:0] ad_out,
  output logic           ad_oe,
  input  logic [ADW-1:0] ad_in
);

  rtc_state_t state_q, state_d;

  logic          wr_q;
  logic          rb_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          phase_end;
  logic          load;
  logic          cur_wr;
  logic          again;

  // second pass of a verified write runs as a read
  assign cur_wr = wr_q & ~rb_q;
  assign load   = (state_d != state_q);
  assign busy   = (state_q != IDLE);

`ifdef RTC_READBACK_EN
  assign again = wr_q & ~rb_q;
`else
  assign again = 1'b0;
`endif

  rtc_phase_timer #(
    .PHASE_CYC(PHASE_CYC)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .phase_end(phase_end)
  );

  always_ff @(posedge clock) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = A_SET;
      GAP:  if (phase_end) state_d = again ? A_SET : IDLE;
      default:
        if (phase_end) state_d = rtc_state_t'(state_q + 3'd1);
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q    <= 1'b0;
      rb_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state_q == IDLE && start) begin
        wr_q    <= wr;
        addr_q  <= addr;
        wdata_q <= wdata;
        rb_q    <= 1'b0;
      end
      if (state_q == D_STB && phase_end && !cur_wr)
        rdata <= ad_in[DW-1:0];
      if (state_q == GAP && phase_end) begin
        if (again) begin
          rb_q <= 1'b1;
        end else begin
          done <= 1'b1;
`ifdef RTC_READBACK_EN
          err  <= rb_q && (rdata != wdata_q);
`endif
        end
      end
    end
  end

  always_comb begin
    {rtc_cs_n, rtc_ad_n, rtc_wr_n, rtc_rd_n} = BUS_IDLE;
    ad_oe  = 1'b0;
    ad_out = '0;
    unique case (state_q)
      A_SET, A_HLD: begin
        rtc_ad_n = 1'b0;
        ad_oe    = 1'b1;
        ad_out   = ADW'(addr_q);
      end
      A_STB: begin
        rtc_ad_n = 1'b0;
        rtc_cs_n = 1'b0;
        rtc_wr_n = 1'b0;
        ad_oe    = 1'b1;
        ad_out   = ADW'(addr_q);
      end
      D_SET, D_HLD: begin
        ad_oe  = cur_wr;
        ad_out = cur_wr ? ADW'(wdata_q) : '0;
      end
      D_STB: begin
        rtc_cs_n = 1'b0;
        rtc_wr_n = ~cur_wr;
        rtc_rd_n = cur_wr;
        ad_oe    = cur_wr;
        ad_out   = cur_wr ? ADW'(wdata_q) : '0;
      end
      default: ;
    endcase
  end

endmodule
